d_cache_dm: RTL

Direct-mapped, blocking, write-through / no-write-allocate data cache placed directly upstream of the data port of the latency-modelled unified memory.
- Serves the CPU data-side read/write requests.
- On a read miss it fetches a 4-word line through the memory's single-word data port.
- Keeps hit/miss statistics counters for cache-baseline performance comparison.

---
 rtl/d_cache_dm_pkg.sv | 40 ++++
 rtl/d_cache_array.sv | 51 +++++
 rtl/d_cache_dm.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/d_cache_dm_pkg.sv
// Shared definitions for the direct-mapped data cache: address split,
// storage geometry, FSM state encoding and CPU opcode constants.
package d_cache_dm_pkg;

    localparam int ADDR_BITS   = 16;
    localparam int DATA_BITS   = 16;
    localparam int OFFSET_BITS = 2;
    localparam int INDEX_BITS  = 3;
    localparam int TAG_BITS    = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
    localparam int LINES       = 1 << INDEX_BITS;
    localparam int WORDS       = 1 << OFFSET_BITS;

    typedef logic [TAG_BITS-1:0]    tag_t;
    typedef logic [INDEX_BITS-1:0]  index_t;
    typedef logic [OFFSET_BITS-1:0] offset_t;
    typedef logic [DATA_BITS-1:0]   word_t;

    typedef struct packed {
        tag_t    tag;
        index_t  index;
        offset_t offset;
    } addr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE,
        ST_RESP
    } state_t;

    // NOP encodings shared with the CPU decoder.
    typedef enum logic [3:0] {
        OPC_NOP = 4'hF
    } opcode_t;

    typedef enum logic [5:0] {
        FUNC_NOP = 6'd0
    } func_t;

endpackage

// File: rtl/d_cache_array.sv
// Tag/valid/data storage for the direct-mapped cache: async-reset valid bits,
// combinational read port, synchronous word and tag write ports.
module d_cache_array
    import d_cache_dm_pkg::*;
(
    input  logic    clk,
    input  logic    reset_n,
    input  index_t  rd_index,
    input  offset_t rd_offset,
    output logic    rd_valid,
    output tag_t    rd_tag,
    output word_t   rd_data,
    input  index_t  wr_index,
    input  offset_t wr_offset,
    input  word_t   wr_data,
    input  logic    word_we,
    input  tag_t    wr_tag,
    input  logic    tag_we,
    input  logic    inval
);

    logic [LINES-1:0]  valid_q;
    tag_t              tag_q  [LINES];
    word_t [WORDS-1:0] data_q [LINES];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index][rd_offset];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else if (inval) begin
            valid_q[wr_index] <= 1'b0;
        end else if (tag_we) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[wr_index] <= wr_tag;
        end
        if (word_we) begin
            data_q[wr_index][wr_offset] <= wr_data;
        end
    end

endmodule

// File: rtl/d_cache_dm.sv
// Direct-mapped, blocking, write-through / no-write-allocate data cache with
// 4-word line fill over a single-word memory port and hit/miss counters.
module d_cache_dm
    import d_cache_dm_pkg::*;
#(
    parameter int MEM_RD_CYCLES = 4,
    parameter int MEM_WR_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        c_readC,
    input  logic        c_writeC,
    input  logic [15:0] c_address,
    input  logic [15:0] c_wdata,
    output logic [15:0] c_rdata,
    output logic        c_ready,
    output logic        m_readM,
    output logic        m_writeM,
    output logic [15:0] m_address,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int CYC_MAX  = (MEM_RD_CYCLES > MEM_WR_CYCLES) ? MEM_RD_CYCLES : MEM_WR_CYCLES;
    localparam int CYC_BITS = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam logic [CYC_BITS-1:0] RD_LAST = CYC_BITS'(MEM_RD_CYCLES - 1);
    localparam logic [CYC_BITS-1:0] WR_LAST = CYC_BITS'(MEM_WR_CYCLES - 1);
    localparam offset_t LAST_WORD = offset_t'(WORDS - 1);

    state_t              state_q, state_d;
    addr_t               addr_q;
    word_t               wdata_q;
    logic                is_write_q;
    logic                hit_q;
    offset_t             word_q;
    logic [CYC_BITS-1:0] cyc_q;

    addr_t   req_addr, cur_addr;
    logic    rd_valid;
    tag_t    rd_tag;
    word_t   rd_data;
    logic    lookup_hit;
    logic    accept;
    logic    word_we, tag_we, inval;
    offset_t arr_wr_offset;
    word_t   arr_wr_data;

    // In IDLE the live request indexes the array; afterwards the latched one does.
    assign req_addr      = addr_t'(c_address);
    assign cur_addr      = (state_q == ST_IDLE) ? req_addr : addr_q;
    assign lookup_hit    = rd_valid && (rd_tag == cur_addr.tag);
    assign arr_wr_offset = (state_q == ST_FILL) ? word_q : addr_q.offset;
    assign arr_wr_data   = (state_q == ST_FILL) ? m_rdata : wdata_q;

    d_cache_array u_array (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_index  (cur_addr.index),
        .rd_offset (cur_addr.offset),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_index  (cur_addr.index),
        .wr_offset (arr_wr_offset),
        .wr_data   (arr_wr_data),
        .word_we   (word_we),
        .wr_tag    (cur_addr.tag),
        .tag_we    (tag_we),
        .inval     (inval)
    );

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_d   = state_q;
        c_ready   = 1'b0;
        c_rdata   = '0;
        m_readM   = 1'b0;
        m_writeM  = 1'b0;
        m_address = '0;
        m_wdata   = '0;
        accept    = 1'b0;
        word_we   = 1'b0;
        tag_we    = 1'b0;
        inval     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (c_writeC) begin
                    accept  = 1'b1;
                    state_d = ST_WRITE;
                end else if (c_readC) begin
                    accept = 1'b1;
                    if (lookup_hit) begin
                        c_ready = 1'b1;
                        c_rdata = rd_data;
                    end else begin
                        inval   = 1'b1;
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                m_readM   = 1'b1;
                m_address = {addr_q.tag, addr_q.index, word_q};
                if (cyc_q == RD_LAST) begin
                    word_we = 1'b1;
                    if (word_q == LAST_WORD) begin
                        tag_we  = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WRITE: begin
                m_writeM  = 1'b1;
                m_address = addr_q;
                m_wdata   = wdata_q;
                if (cyc_q == WR_LAST) begin
                    word_we = hit_q;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                c_ready = 1'b1;
                if (!is_write_q) begin
                    c_rdata = rd_data;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            hit_q      <= 1'b0;
            word_q     <= '0;
            cyc_q      <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q     <= req_addr;
                wdata_q    <= c_wdata;
                is_write_q <= c_writeC;
                hit_q      <= lookup_hit;
                word_q     <= '0;
                cyc_q      <= '0;
                if (lookup_hit) begin
                    hit_count <= hit_count + 16'd1;
                end else begin
                    miss_count <= miss_count + 16'd1;
                end
            end else if (state_q == ST_FILL) begin
                if (cyc_q == RD_LAST) begin
                    cyc_q  <= '0;
                    word_q <= word_q + offset_t'(1);
                end else begin
                    cyc_q <= cyc_q + CYC_BITS'(1);
                end
            end else if (state_q == ST_WRITE) begin
                if (cyc_q == WR_LAST) begin
                    cyc_q <= '0;
                end else begin
                    cyc_q <= cyc_q + CYC_BITS'(1);
                end
            end
        end
    end

endmodule
